// File: rtl/path_trace_ctrl.sv
// Predecessor-walk sequencer: walks from dest back to source, one memory read per hop, streaming
// each node over valid/ready. Define PATH_TRACE_HOP_GUARD_EN to bound walks at MAX_HOPS hops.
module path_trace_ctrl #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned MAX_HOPS = 31
) (
   input  logic              clk_i,
   input  logic              sys_reset_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] source_addr_i,
   input  logic [ADDR_W-1:0] dest_addr_i,
   output logic              pred_rd_en_o,
   output logic [ADDR_W-1:0] pred_rd_addr_o,
   input  logic [ADDR_W-1:0] pred_rd_data_i,
   output logic              node_valid_o,
   input  logic              node_ready_i,
   output logic [ADDR_W-1:0] node_addr_o,
   output logic              node_last_o,
   output logic [ADDR_W-1:0] hop_count_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        err_code_o
);

   typedef enum logic [2:0] {StIdle, StEmit, StIssue, StWait, StDone} state_e;

   localparam logic [1:0] ErrOk     = 2'b00;
   localparam logic [1:0] ErrNoPath = 2'b01;
   localparam logic [1:0] ErrLoop   = 2'b10;

   state_e            state_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] node_addr_q;
   logic              node_last_q;
   logic              node_valid_q;
   logic              pred_rd_en_q;
   logic [ADDR_W-1:0] pred_rd_addr_q;
   logic [ADDR_W-1:0] hop_q;
   logic              done_q;
   logic [1:0]        err_q;

   logic no_pred;
   logic guard_fire;

   // A zero predecessor is only a dead end when the source is not node 0 itself.
   assign no_pred = (pred_rd_data_i == '0) && (src_q != '0);

`ifdef PATH_TRACE_HOP_GUARD_EN
   localparam logic [ADDR_W-1:0] MaxHops = ADDR_W'(MAX_HOPS);
   assign guard_fire = (hop_q == MaxHops) && (pred_rd_data_i != src_q);
`else
   assign guard_fire = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge sys_reset_ni) begin
      if (!sys_reset_ni) begin
         state_q        <= StIdle;
         src_q          <= '0;
         node_addr_q    <= '0;
         node_last_q    <= 1'b0;
         node_valid_q   <= 1'b0;
         pred_rd_en_q   <= 1'b0;
         pred_rd_addr_q <= '0;
         hop_q          <= '0;
         done_q         <= 1'b0;
         err_q          <= ErrOk;
      end else begin
         done_q       <= 1'b0;
         pred_rd_en_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  src_q        <= source_addr_i;
                  node_addr_q  <= dest_addr_i;
                  node_last_q  <= (dest_addr_i == source_addr_i);
                  node_valid_q <= 1'b1;
                  hop_q        <= '0;
                  err_q        <= ErrOk;
                  state_q      <= StEmit;
               end
            end
            StEmit: begin
               if (node_ready_i) begin
                  node_valid_q <= 1'b0;
                  if (node_last_q) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     pred_rd_en_q   <= 1'b1;
                     pred_rd_addr_q <= node_addr_q;
                     state_q        <= StIssue;
                  end
               end
            end
            StIssue: state_q <= StWait;
            StWait: begin
               if (no_pred) begin
                  err_q   <= ErrNoPath;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else if (guard_fire) begin
                  err_q   <= ErrLoop;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  node_addr_q  <= pred_rd_data_i;
                  node_last_q  <= (pred_rd_data_i == src_q);
                  node_valid_q <= 1'b1;
                  // Saturate rather than wrap so a runaway walk never reports a small count.
                  if (hop_q != '1) begin
                     hop_q <= hop_q + 1'b1;
                  end
                  state_q <= StEmit;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign pred_rd_en_o   = pred_rd_en_q;
   assign pred_rd_addr_o = pred_rd_addr_q;
   assign node_valid_o   = node_valid_q;
   assign node_addr_o    = node_addr_q;
   assign node_last_o    = node_last_q;
   assign hop_count_o    = hop_q;
   assign busy_o         = (state_q != StIdle);
   assign done_o         = done_q;
   assign err_code_o     = err_q;

endmodule

// File: tb/tb_path_trace_ctrl.sv
// Bench for path_trace_ctrl: predecessor memory model, node monitor and per-scenario scoreboards.
module tb_path_trace_ctrl;

   localparam int unsigned AW = 5;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          last;
      logic [15:0]   cyc;
   } node_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] source = '0;
   logic [AW-1:0] dest = '0;
   logic          pred_rd_en;
   logic [AW-1:0] pred_rd_addr;
   logic [AW-1:0] pred_rd_data = '0;
   logic          node_valid;
   logic          node_ready = 1'b1;
   logic [AW-1:0] node_addr;
   logic          node_last;
   logic [AW-1:0] hop_count;
   logic          busy;
   logic          done;
   logic [1:0]    err_code;

   logic [AW-1:0] pred_mem [32];
   int            cyc = 0;
   int            base = 0;
   int            checks = 0;
   int            errors = 0;
   int            rd_count = 0;
   int            consec_rd = 0;
   int            done_count = 0;
   int            done_cyc = 0;
   logic          prev_rd = 1'b0;
   node_t         exp_q[$];
   node_t         obs_q[$];

   path_trace_ctrl #(
      .ADDR_W  (AW),
      .MAX_HOPS(31)
   ) dut (
      .clk_i         (clk),
      .sys_reset_ni  (rst_n),
      .start_i       (start),
      .source_addr_i (source),
      .dest_addr_i   (dest),
      .pred_rd_en_o  (pred_rd_en),
      .pred_rd_addr_o(pred_rd_addr),
      .pred_rd_data_i(pred_rd_data),
      .node_valid_o  (node_valid),
      .node_ready_i  (node_ready),
      .node_addr_o   (node_addr),
      .node_last_o   (node_last),
      .hop_count_o   (hop_count),
      .busy_o        (busy),
      .done_o        (done),
      .err_code_o    (err_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pred_rd_en) pred_rd_data <= pred_mem[pred_rd_addr];
   end

   // Monitor: records handshakes, reads and done pulses mid-cycle.
   always @(negedge clk) begin
      node_t o;
      if (node_valid && node_ready) begin
         o.addr = node_addr;
         o.last = node_last;
         o.cyc  = 16'(cyc - base);
         obs_q.push_back(o);
      end
      if (pred_rd_en) begin
         rd_count++;
         if (prev_rd) consec_rd++;
      end
      prev_rd = pred_rd_en;
      if (done) begin
         done_count++;
         done_cyc = cyc - base;
      end
   end

   task automatic clear_state();
      exp_q.delete();
      obs_q.delete();
      rd_count  = 0;
      consec_rd = 0;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic l, input int c);
      node_t e;
      e.addr = a;
      e.last = l;
      e.cyc  = 16'(c);
      exp_q.push_back(e);
   endtask

   task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d);
      @(posedge clk); #1;
      source = s;
      dest   = d;
      start  = 1'b1;
      base   = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int d0;
      d0 = done_count;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_count != d0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [25:0] outs;
      repeat (3) @(posedge clk);
      #1;
      outs = {node_valid, node_last, node_addr, pred_rd_en, pred_rd_addr, hop_count, busy, done,
              err_code};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, want 0", outs);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      outs = {node_valid, node_last, node_addr, pred_rd_en, pred_rd_addr, hop_count, busy, done,
              err_code};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got %h, want 0", outs);
      end
   endtask

   task automatic test_basic_path();
      bit ok;
      node_t e, o;
      pred_mem[9] = 5'd4;
      pred_mem[4] = 5'd2;
      clear_state();
      push_exp(5'd9, 1'b0, 1);
      push_exp(5'd4, 1'b0, 4);
      push_exp(5'd2, 1'b1, 7);
      node_ready = 1'b1;
      launch(5'd2, 5'd9);
      // Start while busy must be ignored.
      @(posedge clk); #1;
      source = 5'd7;
      dest   = 5'd7;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(60, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout: got no done, want done"); end
      checks++;
      if (done_cyc != 8) begin errors++; $display("FAIL basic_done_cyc: got %0d, want 8", done_cyc); end
      checks++;
      if ({hop_count, err_code} !== {5'd2, 2'b00}) begin
         errors++;
         $display("FAIL basic_hop_err: got hop=%0d err=%b, want hop=2 err=00", hop_count, err_code);
      end
      checks++;
      if (rd_count != 2 || consec_rd != 0) begin
         errors++;
         $display("FAIL basic_reads: got %0d reads %0d consecutive, want 2 and 0", rd_count, consec_rd);
      end
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL basic_idle_after: got busy=%b done=%b, want 0 0", busy, done);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL basic_node: got nothing, want addr=%0d cyc=%0d", e.addr, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL basic_node: got addr=%0d last=%b cyc=%0d, want addr=%0d last=%b cyc=%0d",
                        o.addr, o.last, o.cyc, e.addr, e.last, e.cyc);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra: got %0d nodes, want 0", obs_q.size()); end
   endtask

   task automatic test_single_node();
      bit ok;
      node_t e, o;
      clear_state();
      push_exp(5'd7, 1'b1, 1);
      launch(5'd7, 5'd7);
      wait_done(20, ok);
      checks++;
      if (!ok || done_cyc != 2) begin
         errors++;
         $display("FAIL single_done: got ok=%b cyc=%0d, want ok=1 cyc=2", ok, done_cyc);
      end
      checks++;
      if ({hop_count, err_code} !== 7'd0 || rd_count != 0) begin
         errors++;
         $display("FAIL single_state: got hop=%0d err=%b reads=%0d, want 0 00 0", hop_count, err_code,
                  rd_count);
      end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL single_node_count: got %0d, want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         if (o !== e) begin
            errors++;
            $display("FAIL single_node: got addr=%0d last=%b cyc=%0d, want addr=%0d last=%b cyc=%0d",
                     o.addr, o.last, o.cyc, e.addr, e.last, e.cyc);
         end
      end
   endtask

   task automatic test_no_path();
      bit ok;
      node_t e, o;
      pred_mem[12] = 5'd0;
      clear_state();
      push_exp(5'd12, 1'b0, 1);
      launch(5'd3, 5'd12);
      wait_done(20, ok);
      checks++;
      if (!ok || done_cyc != 4) begin
         errors++;
         $display("FAIL nopath_done: got ok=%b cyc=%0d, want ok=1 cyc=4", ok, done_cyc);
      end
      checks++;
      if (err_code !== 2'b01) begin errors++; $display("FAIL nopath_err: got %b, want 01", err_code); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err_code !== 2'b01 || busy !== 1'b0) begin
         errors++;
         $display("FAIL nopath_hold: got err=%b busy=%b, want 01 0", err_code, busy);
      end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL nopath_node_count: got %0d, want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         if (o !== e) begin
            errors++;
            $display("FAIL nopath_node: got addr=%0d last=%b cyc=%0d, want addr=%0d last=%b cyc=%0d",
                     o.addr, o.last, o.cyc, e.addr, e.last, e.cyc);
         end
      end
   endtask

   task automatic test_stall();
      int d0, rel;
      bit ok;
      node_t e, o;
      pred_mem[9] = 5'd4;
      pred_mem[4] = 5'd2;
      clear_state();
      push_exp(5'd9, 1'b0, 1);
      push_exp(5'd4, 1'b0, 9);
      push_exp(5'd2, 1'b1, 12);
      node_ready = 1'b1;
      launch(5'd2, 5'd9);
      d0 = done_count;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         rel = cyc - base;
         node_ready = !(rel >= 4 && rel <= 8);
         #1;
         if (rel >= 4 && rel <= 8) begin
            checks++;
            if ({node_valid, node_addr, pred_rd_en} !== {1'b1, 5'd4, 1'b0}) begin
               errors++;
               $display("FAIL stall_hold c%0d: got valid=%b addr=%0d rd=%b, want 1 4 0", rel, node_valid,
                        node_addr, pred_rd_en);
            end
         end
         if (done_count != d0) begin
            ok = 1'b1;
            break;
         end
      end
      node_ready = 1'b1;
      checks++;
      if (!ok || done_cyc != 13) begin
         errors++;
         $display("FAIL stall_done: got ok=%b cyc=%0d, want ok=1 cyc=13", ok, done_cyc);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL stall_node: got nothing, want addr=%0d cyc=%0d", e.addr, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL stall_node: got addr=%0d last=%b cyc=%0d, want addr=%0d last=%b cyc=%0d",
                        o.addr, o.last, o.cyc, e.addr, e.last, e.cyc);
            end
         end
      end
   endtask

   task automatic test_src_zero();
      bit ok;
      node_t e, o;
      pred_mem[9] = 5'd4;
      pred_mem[4] = 5'd0;
      clear_state();
      push_exp(5'd9, 1'b0, 1);
      push_exp(5'd4, 1'b0, 4);
      push_exp(5'd0, 1'b1, 7);
      launch(5'd0, 5'd9);
      wait_done(60, ok);
      checks++;
      if (!ok || done_cyc != 8 || {hop_count, err_code} !== {5'd2, 2'b00}) begin
         errors++;
         $display("FAIL zero_src_end: got ok=%b cyc=%0d hop=%0d err=%b, want 1 8 2 00", ok, done_cyc,
                  hop_count, err_code);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL zero_src_node: got nothing, want addr=%0d cyc=%0d", e.addr, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL zero_src_node: got addr=%0d last=%b cyc=%0d, want addr=%0d last=%b cyc=%0d",
                        o.addr, o.last, o.cyc, e.addr, e.last, e.cyc);
            end
         end
      end
   endtask

   task automatic test_loop();
      int d0;
      d0 = done_count;
      pred_mem[5] = 5'd6;
      pred_mem[6] = 5'd5;
      clear_state();
`ifdef PATH_TRACE_HOP_GUARD_EN
      begin
         bit ok;
         node_t e, o;
         for (int i = 0; i < 32; i++) push_exp((i % 2 == 0) ? 5'd5 : 5'd6, 1'b0, 1 + 3 * i);
         launch(5'd1, 5'd5);
         wait_done(150, ok);
         checks++;
         if (!ok || done_cyc != 97 || {hop_count, err_code} !== {5'd31, 2'b10}) begin
            errors++;
            $display("FAIL loop_guard: got ok=%b cyc=%0d hop=%0d err=%b, want 1 97 31 10", ok, done_cyc,
                     hop_count, err_code);
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
               errors++;
               $display("FAIL loop_node: got nothing, want addr=%0d cyc=%0d", e.addr, e.cyc);
            end else begin
               o = obs_q.pop_front();
               if (o !== e) begin
                  errors++;
                  $display("FAIL loop_node: got addr=%0d cyc=%0d, want addr=%0d cyc=%0d", o.addr, o.cyc,
                           e.addr, e.cyc);
               end
            end
         end
      end
`else
      begin
         int busy_low;
         busy_low = 0;
         launch(5'd1, 5'd5);
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) busy_low++;
         end
         checks++;
         if (busy_low != 0 || done_count != d0) begin
            errors++;
            $display("FAIL loop_runs: got %0d idle cycles %0d dones, want 0 0", busy_low,
                     done_count - d0);
         end
         checks++;
         if ({hop_count, err_code} !== {5'd31, 2'b00}) begin
            errors++;
            $display("FAIL loop_saturate: got hop=%0d err=%b, want 31 00", hop_count, err_code);
         end
         #1 rst_n = 1'b0;
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
      end
`endif
      clear_state();
   endtask

   task automatic test_reset_mid_walk();
      int d0;
      bit ok;
      logic [25:0] outs;
      node_t e, o;
      pred_mem[9] = 5'd4;
      pred_mem[4] = 5'd2;
      node_ready = 1'b1;
      launch(5'd2, 5'd9);
      repeat (2) @(posedge clk);
      #2;
      d0 = done_count;
      rst_n = 1'b0;
      #1;
      outs = {node_valid, node_last, node_addr, pred_rd_en, pred_rd_addr, hop_count, busy, done,
              err_code};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL async_reset: got %h, want 0", outs); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (done_count != d0) begin
         errors++;
         $display("FAIL reset_no_done: got %0d pulses, want 0", done_count - d0);
      end
      clear_state();
      push_exp(5'd9, 1'b0, 1);
      push_exp(5'd4, 1'b0, 4);
      push_exp(5'd2, 1'b1, 7);
      launch(5'd2, 5'd9);
      wait_done(60, ok);
      checks++;
      if (!ok || done_cyc != 8 || hop_count !== 5'd2) begin
         errors++;
         $display("FAIL rewalk_done: got ok=%b cyc=%0d hop=%0d, want 1 8 2", ok, done_cyc, hop_count);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL rewalk_node: got nothing, want addr=%0d cyc=%0d", e.addr, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL rewalk_node: got addr=%0d last=%b cyc=%0d, want addr=%0d last=%b cyc=%0d",
                        o.addr, o.last, o.cyc, e.addr, e.last, e.cyc);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) pred_mem[i] = '0;
      test_reset();
      test_basic_path();
      test_single_node();
      test_no_path();
      test_stall();
      test_src_zero();
      test_loop();
      test_reset_mid_walk();
      checks++;
      if (consec_rd != 0) begin errors++; $display("FAIL back_to_back_reads: got %0d, want 0", consec_rd); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
